// File: rtl/psa_sub_seq_if.sv
// Bus bundle for the nibble-serial partitioned add/subtract unit.
// The master side issues operations and the slave side (the unit) returns results.
interface psa_sub_seq_if;
    logic        start;
    logic        sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic [3:0]  lane_ovfl;
    logic        Error;

    modport master (
        output start, sub, A, B,
        input  busy, done, Diff, lane_ovfl, Error
    );

    modport slave (
        input  start, sub, A, B,
        output busy, done, Diff, lane_ovfl, Error
    );
endinterface

// File: rtl/psa_sub_seq.sv
// Four independent 4-bit two's-complement lane add/subtract operations, one lane per cycle,
// with per-lane overflow flags and optional saturation; results publish only on completion.
module psa_sub_seq #(
    parameter int SATURATE = 1
) (
    input  logic          clk,
    input  logic          rst,
    psa_sub_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [15:0] a_q, b_q, work_q, diff_q;
    logic        sub_q;
    logic [1:0]  cnt_q;
    logic [3:0]  flags_q, ovfl_q;

    logic [3:0]  base;
    logic [3:0]  a_k, b_k, raw, lane;
    logic        ovf;
    logic [15:0] work_nxt;
    logic [3:0]  flags_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt_q == 2'd3) state_nxt = DONE;
            end
            DONE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Lane datapath: no carry or borrow crosses a nibble boundary.
    always_comb begin
        base      = {cnt_q, 2'b00};
        a_k       = a_q[base +: 4];
        b_k       = b_q[base +: 4];
        raw       = sub_q ? (a_k - b_k) : (a_k + b_k);
        ovf       = (sub_q ? (a_k[3] != b_k[3]) : (a_k[3] == b_k[3])) && (raw[3] != a_k[3]);
        lane      = ((SATURATE != 0) && ovf) ? (a_k[3] ? 4'h8 : 4'h7) : raw;
        work_nxt  = work_q;
        work_nxt[base +: 4] = lane;
        flags_nxt = flags_q;
        flags_nxt[cnt_q] = ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            work_q  <= '0;
            flags_q <= '0;
            diff_q  <= '0;
            ovfl_q  <= '0;
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            sub_q   <= bus.sub;
            cnt_q   <= '0;
            work_q  <= '0;
            flags_q <= '0;
        end else if (state == RUN) begin
            work_q  <= work_nxt;
            flags_q <= flags_nxt;
            cnt_q   <= cnt_q + 2'd1;
            // Visible outputs change only when the last lane lands.
            if (cnt_q == 2'd3) begin
                diff_q <= work_nxt;
                ovfl_q <= flags_nxt;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.Diff      = diff_q;
    assign bus.lane_ovfl = ovfl_q;
    assign bus.Error     = |ovfl_q;
endmodule

// File: tb/tb_psa_sub_seq.sv
// Bench for psa_sub_seq: saturating and wrapping instances driven in lockstep,
// with a queue of expected results popped on each done pulse.
module tb_psa_sub_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a, b;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    typedef struct {
        logic [15:0] ds;
        logic [15:0] dw;
        logic [3:0]  ov;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    psa_sub_seq_if if_s ();
    psa_sub_seq_if if_w ();

    assign if_s.start = start;
    assign if_s.sub   = sub;
    assign if_s.A     = a;
    assign if_s.B     = b;
    assign if_w.start = start;
    assign if_w.sub   = sub;
    assign if_w.A     = a;
    assign if_w.B     = b;

    psa_sub_seq #(.SATURATE(1)) dut_s (.clk(clk), .rst(rst), .bus(if_s));
    psa_sub_seq #(.SATURATE(0)) dut_w (.clk(clk), .rst(rst), .bus(if_w));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: evaluate each lane as a signed integer and range-check the true result.
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb, input logic ms);
        exp_t e;
        int   sa, sv, full;
        logic [3:0] w;
        e.ds = '0;
        e.dw = '0;
        e.ov = '0;
        for (int k = 0; k < 4; k++) begin
            sa = int'(ma[4*k +: 4]);
            sv = int'(mb[4*k +: 4]);
            if (sa > 7) sa -= 16;
            if (sv > 7) sv -= 16;
            full = ms ? (sa - sv) : (sa + sv);
            w = 4'(full);
            e.dw[4*k +: 4] = w;
            if (full > 7) begin
                e.ov[k] = 1'b1;
                e.ds[4*k +: 4] = 4'h7;
            end else if (full < -8) begin
                e.ov[k] = 1'b1;
                e.ds[4*k +: 4] = 4'h8;
            end else begin
                e.ds[4*k +: 4] = w;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst && if_s.done) begin
            done_cnt++;
            check("done_pair", if_w.done, 1);
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_diff_sat",  if_s.Diff, mon_e.ds);
                check("sb_diff_wrap", if_w.Diff, mon_e.dw);
                check("sb_ovfl_sat",  if_s.lane_ovfl, mon_e.ov);
                check("sb_ovfl_wrap", if_w.lane_ovfl, mon_e.ov);
                check("sb_error_sat", if_s.Error, |mon_e.ov);
                check("sb_error_wrap", if_w.Error, |mon_e.ov);
            end
        end
    end

    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic is);
        a = ia;
        b = ib;
        sub = is;
        start = 1'b1;
        sb.push_back(model(ia, ib, is));
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bz, input bit hold_en, input logic [15:0] hold);
        lat = 1;
        bz = 0;
        while (!if_s.done && lat < 30) begin
            if (if_s.busy) bz++;
            if (hold_en) check("diff_hold", if_s.Diff, hold);
            @(negedge clk);
            lat++;
        end
        if (!if_s.done) check("done_timeout", 0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, {if_s.busy, if_w.busy}, 0);
        check({tag, "_done"}, {if_s.done, if_w.done}, 0);
        check({tag, "_diff_s"}, if_s.Diff, 0);
        check({tag, "_diff_w"}, if_w.Diff, 0);
        check({tag, "_ovfl"}, {if_s.lane_ovfl, if_w.lane_ovfl}, 0);
        check({tag, "_error"}, {if_s.Error, if_w.Error}, 0);
    endtask

    initial begin
        int lat, bz, d0;
        rst = 1'b1;
        start = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        issue(16'h1234, 16'h1111, 1'b0);
        wait_done(lat, bz, 1'b0, '0);
        check("add_latency", lat, 5);
        check("add_busy_cycles", bz, 4);
        check("add_diff", if_s.Diff, 16'h2345);
        check("add_ovfl", if_s.lane_ovfl, 4'b0000);
        check("add_error", if_s.Error, 0);
        @(negedge clk);
        check("done_one_cycle", if_s.done, 0);
        check("idle_busy", if_s.busy, 0);
        check("idle_hold", if_s.Diff, 16'h2345);

        issue(16'h7777, 16'h1111, 1'b0);
        wait_done(lat, bz, 1'b0, '0);
        check("sat_add_diff", if_s.Diff, 16'h7777);
        check("wrap_add_diff", if_w.Diff, 16'h8888);
        check("sat_add_ovfl", if_s.lane_ovfl, 4'b1111);
        check("sat_add_error", if_s.Error, 1);
        @(negedge clk);

        issue(16'h8000, 16'h1000, 1'b1);
        wait_done(lat, bz, 1'b0, '0);
        check("sat_sub_diff", if_s.Diff, 16'h8000);
        check("wrap_sub_diff", if_w.Diff, 16'h7000);
        check("sub_ovfl_s", if_s.lane_ovfl, 4'b1000);
        check("sub_ovfl_w", if_w.lane_ovfl, 4'b1000);
        check("sub_error", if_w.Error, 1);
        @(negedge clk);

        issue(16'h5432, 16'h1111, 1'b1);
        wait_done(lat, bz, 1'b0, '0);
        check("sub_plain_diff", if_s.Diff, 16'h4321);
        check("sub_plain_error", if_s.Error, 0);
        @(negedge clk);

        // start raised mid-run with other operands must be dropped
        issue(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        d0 = done_cnt;
        a = 16'hffff;
        b = 16'hffff;
        sub = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bz, 1'b0, '0);
        check("ignore_latency", lat, 3);
        check("ignore_diff", if_s.Diff, 16'h3333);
        repeat (8) @(negedge clk);
        check("ignore_single_done", done_cnt - d0, 1);
        check("ignore_keep", if_s.Diff, 16'h3333);

        issue(16'h0123, 16'h7654, 1'b0);
        wait_done(lat, bz, 1'b0, '0);
        check("b2b_first", if_s.Diff, 16'h7777);
        issue(16'h4444, 16'h5555, 1'b1);
        check("b2b_busy", if_s.busy, 1);
        wait_done(lat, bz, 1'b1, 16'h7777);
        check("b2b_gap", lat, 5);
        check("b2b_second", if_s.Diff, 16'hffff);

        for (int i = 0; i < 24; i++) begin
            issue(16'($urandom), 16'($urandom), 1'($urandom));
            wait_done(lat, bz, 1'b0, '0);
            check("rand_latency", lat, 5);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);

        issue(16'h7777, 16'h7777, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        d0 = done_cnt;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        issue(16'h2222, 16'h1111, 1'b1);
        wait_done(lat, bz, 1'b0, '0);
        check("after_abort_latency", lat, 5);
        check("after_abort_diff", if_s.Diff, 16'h1111);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
